regfile_port_scheduler: RTL and testbench
=========================================

// Module: regfile_port_scheduler
// PURPOSE
//  Sequences access to the 32x32 register file: 2 registered read ports, 1 write port, x0 hard-wired.
//  Keeps a busy scoreboard and holds issue on RAW/WAW hazards.
//  Round-robin arbitrates NWB writeback sources onto the single write port.
//  Forwards same-edge write data past the regfile's registered read. Sits between decode/issue and the regfile.
// PARAMETERS
//  XLEN  32  data width
//  NREG  32  register count; index 0 is hard-wired zero
//  AW    5   register address width, clog2(NREG)
//  NWB   2   writeback requesters (0 = ALU, 1 = LSU)
// PORTS
//  clk        in   1         clock; all state updates on posedge
//  rst        in   1         synchronous, active-high reset
//  iss_valid  in   1         issue request
//  iss_rs1    in   AW        source 1 address
//  iss_rs2    in   AW        source 2 address
//  iss_rd     in   AW        destination address
//  iss_wr     in   1         instruction will write iss_rd
//  iss_ready  out  1         issue accepted this cycle (comb)
//  rd_valid   out  1         operands valid, 1 cycle after accept
//  rd_data1   out  XLEN      operand 1
//  rd_data2   out  XLEN      operand 2
//  wb_valid   in   NWB       writeback request per source
//  wb_addr    in   AW*NWB    writeback address, packed by source
//  wb_data    in   XLEN*NWB  writeback data, packed by source
//  wb_ready   out  NWB       one-hot grant (comb)
//  rf_raddr1  out  AW        regfile ReadPort1 (= iss_rs1)
//  rf_raddr2  out  AW        regfile ReadPort2 (= iss_rs2)
//  rf_rdata1  in   XLEN      regfile ReadData1
//  rf_rdata2  in   XLEN      regfile ReadData2
//  rf_we      out  1         regfile WriteEnable
//  rf_waddr   out  AW        regfile WritePort
//  rf_wdata   out  XLEN      regfile WriteData
// BEHAVIOUR
//  Reset:
//  - busy[NREG-1:0]=0, rr_ptr=0, rd_valid=0, rd_data1/2=0, byp flags=0.
//  - Writebacks in flight during rst are dropped; no rf_we while rst=1.
//  Arbiter:
//  - Round-robin over wb_valid, starting at rr_ptr. wb_ready[g]=1 for granted g only; zero grants when none valid.
//  - On grant: rr_ptr <= (g+1) mod NWB; rr_ptr holds when idle.
//  - rf_waddr/rf_wdata = wb_addr/wb_data of g.
//  - rf_we = grant & (waddr!=0). A grant to x0 completes the handshake; no write, no busy change.
//  Scoreboard:
//  - busy[0] is constant 0.
//  - wfwd(r) = rf_we & rf_waddr==r & r!=0.
//  - src_ok(r) = !busy[r] | wfwd(r).
//  - iss_ready = iss_valid & !rst & src_ok(rs1) & src_ok(rs2) & !(iss_wr & busy[rd] & !wfwd(rd)).
//  - Accept with iss_wr & rd!=0: busy[rd] <= 1. This wins over a same-cycle clear of the same rd.
//  - rf_we: busy[rf_waddr] <= 0, unless re-set by that rule.
//  - A writeback to a non-busy reg is legal; the regfile is written and busy stays 0.
//  Read path (regfile read is registered: old value on a same-edge write):
//  - rf_raddr1/2 driven from iss_rs1/2 every cycle.
//  - On accept, byp1 <= wfwd(rs1) and bdata1 <= rf_wdata; likewise byp2 and bdata2 for rs2.
//  - Next cycle: rd_valid=1, rd_data1 = byp1 ? bdata1 : rf_rdata1. rd_data2 the same.
//  - Without accept: rd_valid=0 and rd_data holds its last value.
//  - Latency: accept at edge N -> operands valid in cycle N+1. Throughput: 1 issue/cycle.
//  - rs=0 always yields 0; it is never busy and never bypassed.
// STRUCTURE
//  Package regfile_pkg holds XLEN, NREG, AW, the REG_ZERO constant, and the wb_src_e enum (WB_ALU=0, WB_LSU=1).
//  One sub-module: rr_arbiter (NWB req -> one-hot grant, rr_ptr state). Scoreboard, bypass and read path stay inline.
// TESTING
//  - Reset: rst=1 for 2 cycles with all valids high -> rf_we=0, rd_valid=0, iss_ready=0; busy=0 after release.
//  - RAW stall: issue rd=5 wr=1, then rs1=5 -> iss_ready=0 until wb x5=0xDEADBEEF is granted.
//    That grant cycle gives iss_ready=1; next cycle rd_data1=0xDEADBEEF via bypass.
//  - Contention: both sources valid for 4 cycles (rr_ptr=0) -> grants ALU, LSU, ALU, LSU.
//    Each rf_waddr/rf_wdata matches the granted source.
//  - WAW + set/clear: x7 busy; issue rd=7 in the same cycle as the x7 writeback -> accepted.
//    busy[7] stays 1; a later rs1=7 stalls.
//  - x0: wb to x0 -> wb_ready=1, rf_we=0. Issue rs1=0 rs2=0 rd=0 -> accepted; rd_data1=rd_data2=0; busy unchanged.
//  - Plain read: Reg[3]=0x12 preset, x3 not busy -> rs1=3 accepted; next cycle rd_valid=1, rd_data1=0x12.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, constants and types for the register-file port scheduler.
package regfile_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NWB  = 2;

  localparam logic [AW-1:0] REG_ZERO = AW'(0);

  // Writeback source identifiers, in arbitration index order.
  typedef enum logic [0:0] {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // One writeback request as seen on the shared write port.
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at rr_ptr.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;

  // Requests are ignored while reset is held so nothing is granted.
  always_comb begin
    int unsigned idx;
    int unsigned nxt;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    idx      = 0;
    nxt      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx] && !rst) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        gnt_any  = 1'b1;
      end
    end
    if (gnt_any) begin
      nxt      = 32'(gnt_idx) + 1;
      rr_ptr_d = (nxt >= N) ? PW'(0) : PW'(nxt);
    end
  end

  // Pointer register; moves past the winner, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Issue/writeback sequencer in front of a 2R1W registered-read register file.
module regfile_port_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NWB_P = NWB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rs1,
  input  logic [AW-1:0]         iss_rs2,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  iss_wr,
  output logic                  iss_ready,
  output logic                  rd_valid,
  output logic [XLEN-1:0]       rd_data1,
  output logic [XLEN-1:0]       rd_data2,
  input  logic [NWB_P-1:0]      wb_valid,
  input  logic [AW*NWB_P-1:0]   wb_addr,
  input  logic [XLEN*NWB_P-1:0] wb_data,
  output logic [NWB_P-1:0]      wb_ready,
  output logic [AW-1:0]         rf_raddr1,
  output logic [AW-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]       rf_rdata1,
  input  logic [XLEN-1:0]       rf_rdata2,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int unsigned PW = (NWB_P > 1) ? $clog2(NWB_P) : 1;

  logic [NWB_P-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  wb_req_t          wb_sel;

  logic             wfwd1, wfwd2, wfwdd;
  logic             src_ok1, src_ok2;
  logic             accept;

  logic [NREG-1:0]  busy_q, busy_d;
  logic             rd_valid_q, rd_valid_d;
  logic             byp1_q, byp1_d, byp2_q, byp2_d;
  logic             z1_q, z1_d, z2_q, z2_d;
  logic [XLEN-1:0]  bdata1_q, bdata1_d, bdata2_q, bdata2_d;
  logic [XLEN-1:0]  hold1_q, hold1_d, hold2_q, hold2_d;

  rr_arbiter #(
    .N  (NWB_P),
    .PW (PW)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (wb_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign wb_ready  = gnt;
  assign rf_raddr1 = iss_rs1;
  assign rf_raddr2 = iss_rs2;

  // Steer the granted source onto the write port; x0 grants complete without a write.
  always_comb begin
    wb_sel.addr = wb_addr[32'(gnt_idx)*AW +: AW];
    wb_sel.data = wb_data[32'(gnt_idx)*XLEN +: XLEN];
    rf_waddr    = wb_sel.addr;
    rf_wdata    = wb_sel.data;
    rf_we       = gnt_any && (wb_sel.addr != REG_ZERO);
  end

  // Hazard check: a source or destination is free if idle or written this very edge.
  always_comb begin
    wfwd1     = rf_we && (rf_waddr == iss_rs1);
    wfwd2     = rf_we && (rf_waddr == iss_rs2);
    wfwdd     = rf_we && (rf_waddr == iss_rd);
    src_ok1   = !busy_q[iss_rs1] || wfwd1;
    src_ok2   = !busy_q[iss_rs2] || wfwd2;
    iss_ready = iss_valid && !rst && src_ok1 && src_ok2 &&
                !(iss_wr && busy_q[iss_rd] && !wfwdd);
    accept    = iss_ready;
  end

  // Scoreboard update: clear on write, then a new claim on the same reg wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) busy_d[rf_waddr] = 1'b0;
    if (accept && iss_wr && (iss_rd != REG_ZERO)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Capture bypass state at accept; the regfile would return the pre-write value.
  always_comb begin
    rd_valid_d = accept;
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    z1_d       = z1_q;
    z2_d       = z2_q;
    bdata1_d   = bdata1_q;
    bdata2_d   = bdata2_q;
    if (accept) begin
      byp1_d   = wfwd1;
      byp2_d   = wfwd2;
      z1_d     = (iss_rs1 == REG_ZERO);
      z2_d     = (iss_rs2 == REG_ZERO);
      bdata1_d = rf_wdata;
      bdata2_d = rf_wdata;
    end
  end

  // Operand mux one cycle after accept; otherwise present the last operands.
  always_comb begin
    if (rd_valid_q) begin
      rd_data1 = z1_q ? '0 : (byp1_q ? bdata1_q : rf_rdata1);
      rd_data2 = z2_q ? '0 : (byp2_q ? bdata2_q : rf_rdata2);
    end else begin
      rd_data1 = hold1_q;
      rd_data2 = hold2_q;
    end
    rd_valid = rd_valid_q;
    hold1_d  = rd_data1;
    hold2_d  = rd_data2;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rd_valid_q <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      z1_q       <= 1'b0;
      z2_q       <= 1'b0;
      bdata1_q   <= '0;
      bdata2_q   <= '0;
      hold1_q    <= '0;
      hold2_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      z1_q       <= z1_d;
      z2_q       <= z2_d;
      bdata1_q   <= bdata1_d;
      bdata2_q   <= bdata2_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Scoreboard bench for regfile_port_scheduler with a behavioural registered-read regfile.
module tb_regfile_port_scheduler;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [AW-1:0]     iss_rs1, iss_rs2, iss_rd;
  logic              iss_wr;
  logic              iss_ready;
  logic              rd_valid;
  logic [XLEN-1:0]   rd_data1, rd_data2;
  logic [1:0]        wb_valid;
  logic [2*AW-1:0]   wb_addr;
  logic [2*XLEN-1:0] wb_data;
  logic [1:0]        wb_ready;
  logic [AW-1:0]     rf_raddr1, rf_raddr2, rf_waddr;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2, rf_wdata;
  logic              rf_we;

  typedef struct packed {
    logic [1:0]      gnt;
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wbx_t;

  wbx_t        wbq[$];
  logic [63:0] rdq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_port_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_wr    (iss_wr),
    .iss_ready (iss_ready),
    .rd_valid  (rd_valid),
    .rd_data1  (rd_data1),
    .rd_data2  (rd_data2),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  // Register file: registered read returns the old value on a same-edge write.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 3) ? 32'h12 : 32'h0;
    end else if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
    end
    rf_rdata1 <= mem[rf_raddr1];
    rf_rdata2 <= mem[rf_raddr2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT presents operands or a write grant.
  always @(negedge clk) begin : mon
    wbx_t        w;
    logic [63:0] e;
    if (rd_valid === 1'b1) begin
      if (rdq.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'd0);
      else begin
        e = rdq.pop_front();
        chk("rd_data1", 64'(rd_data1), 64'(e[63:32]));
        chk("rd_data2", 64'(rd_data2), 64'(e[31:0]));
      end
    end
    if (wb_ready != 2'b00 || rf_we === 1'b1) begin
      if (wbq.size() == 0) chk("wb_unexpected", 64'(wb_ready), 64'd0);
      else begin
        w = wbq.pop_front();
        chk("wb_ready", 64'(wb_ready), 64'(w.gnt));
        chk("rf_we",    64'(rf_we),    64'(w.we));
        chk("rf_waddr", 64'(rf_waddr), 64'(w.addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(w.data));
      end
    end
  end

  // One cycle of stimulus with its hand-computed expectations.
  task automatic tick(input string tag, input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic wr, input logic er,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [1:0] wv, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] eg);
    iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wr = wr;
    wb_valid = wv; wb_addr = {a1, a0}; wb_data = {d1, d0};
    if (eg == 2'b01) wbq.push_back('{eg, (a0 != 5'd0), a0, d0});
    else if (eg == 2'b10) wbq.push_back('{eg, (a1 != 5'd0), a1, d1});
    if (er) rdq.push_back({e1, e2});
    @(negedge clk);
    chk({tag, " iss_ready"}, 64'(iss_ready), 64'(er));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iss_valid = 1'b1; iss_rs1 = 5'd0; iss_rs2 = 5'd0; iss_rd = 5'd9; iss_wr = 1'b1;
    wb_valid = 2'b11; wb_addr = {5'd9, 5'd9}; wb_data = {32'hBAD, 32'hBAD};
    repeat (2) begin
      @(negedge clk);
      chk("rst rf_we",     64'(rf_we),     64'd0);
      chk("rst wb_ready",  64'(wb_ready),  64'd0);
      chk("rst iss_ready", 64'(iss_ready), 64'd0);
      chk("rst rd_valid",  64'(rd_valid),  64'd0);
      chk("rst rd_data1",  64'(rd_data1),  64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // x9 was a reset-time destination: must be free and unwritten.
    tick("A", 1, 9, 0, 5, 1, 1, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("B", 1, 3, 0, 0, 0, 1, 32'h12, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("C", 1, 5, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("D", 1, 5, 3, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    chk("hold rd_valid", 64'(rd_valid), 64'd0);
    chk("hold rd_data1", 64'(rd_data1), 64'h12);
    chk("hold rd_data2", 64'(rd_data2), 64'h0);
    tick("E", 1, 5, 3, 0, 0, 1, 32'hDEADBEEF, 32'h12, 2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b01);
    tick("F", 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 12, 32'h1111, 2'b10);

    // Contention from rr_ptr=0: ALU, LSU, ALU, LSU.
    for (int k = 0; k < 4; k++)
      tick("G", 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 10, 32'hA0 + 32'(k), 11, 32'hB0 + 32'(k),
           (k % 2 == 0) ? 2'b01 : 2'b10);

    tick("K", 1, 10, 11, 0, 0, 1, 32'hA2, 32'hB3, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("L", 1, 12, 0, 7, 1, 1, 32'h1111, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("M", 1, 0, 0, 7, 1, 1, 32'h0, 32'h0, 2'b01, 7, 32'h77, 0, 0, 2'b01);
    tick("N", 1, 7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("O", 1, 0, 0, 0, 1, 1, 32'h0, 32'h0, 2'b10, 0, 0, 0, 32'hFFFF, 2'b10);
    tick("P", 1, 7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("Q", 1, 7, 10, 0, 0, 1, 32'h99, 32'hA2, 2'b01, 7, 32'h99, 0, 0, 2'b01);
    tick("R", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);
    tick("S", 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00);

    @(negedge clk); #1;
    chk("rdq drained", 64'(rdq.size()), 64'd0);
    chk("wbq drained", 64'(wbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
